// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and default widths for the instruction-memory loader
package imem_loader_pkg;
  localparam int INSTR_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction stream in and instruction-memory write port out
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic [INSTR_W-1:0] in_data;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  modport master(
    output in_valid, in_data, in_last,
    input in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave(
    input in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams instruction words into imem from address 0, holds the CPU until the last write lands
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic clk,
  input logic rst_n,
  input logic load_start,
  input logic halt,
  imem_loader_if.slave bus,
  output logic cpu_run,
  output logic [ADDR_W:0] prog_len,
  output logic [INSTR_W-1:0] csum,
  output logic done,
  output logic err_overflow
);
  localparam logic [ADDR_W:0] TOP = {1'b0, {ADDR_W{1'b1}}};
  state_t state, next;
  logic hs, start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    bus.in_ready = state == LOAD;
    cpu_run = state == RUN;
    err_overflow = state == ERR;
    hs = bus.in_valid & (state == LOAD);
    start = load_start & (state inside {IDLE, RUN, ERR});
    unique case (state)
      IDLE: next = load_start ? LOAD : IDLE;
      LOAD: next = !hs ? LOAD : bus.in_last ? FLUSH : prog_len == TOP ? ERR : LOAD;
      FLUSH: next = RUN;
      RUN: next = load_start ? LOAD : halt ? IDLE : RUN;
      ERR: next = load_start ? LOAD : ERR;
      default: next = IDLE;
    endcase
  end
  // write port is registered, so FLUSH exists to let the final write retire before cpu_run
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      prog_len <= '0;
      csum <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FLUSH;
      bus.mem_we <= hs;
      if (hs) begin
        bus.mem_addr <= prog_len[ADDR_W-1:0];
        bus.mem_wdata <= bus.in_data;
      end
      if (start) begin
        prog_len <= '0;
        csum <= '0;
      end else if (hs) begin
        prog_len <= prog_len + 1'b1;
        csum <= csum + bus.in_data;
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed table, corner sequences and random loads against a list-based model
module tb_imem_loader;
  import imem_loader_pkg::*;
  localparam int IW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;
  typedef logic [IW-1:0] prog_t[8];
  typedef struct {
    string name;
    prog_t w;
    int n;
    logic [7:0] gaps;
    bit last;
    logic [AW:0] len;
    logic [IW-1:0] sum;
    bit err;
  } vec_t;
  logic clk = 0, rst_n = 0, load_start = 0, halt = 0;
  logic cpu_run, done, err_overflow;
  logic [AW:0] prog_len;
  logic [IW-1:0] csum;
  int total = 0, bad = 0, done_cnt = 0;
  logic [AW+IW-1:0] wq[$];
  vec_t tab[7];
  imem_loader_if #(.INSTR_W(IW), .ADDR_W(AW)) bus ();
  imem_loader #(.INSTR_W(IW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .halt(halt), .bus(bus),
    .cpu_run(cpu_run), .prog_len(prog_len), .csum(csum), .done(done), .err_overflow(err_overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});
    if (done) done_cnt++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic start_load;
    load_start = 1;
    tick;
    load_start = 0;
    chk("start_ready", bus.in_ready, 1);
    chk("start_len", prog_len, 0);
    chk("start_csum", csum, 0);
    chk("start_run", cpu_run, 0);
    chk("start_err", err_overflow, 0);
    wq.delete();
    done_cnt = 0;
  endtask
  task automatic feed(input prog_t w, input int n, input logic [7:0] gaps, input bit last);
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) begin
        bus.in_valid = 0;
        bus.in_data = IW'($urandom);
        bus.in_last = 1'($urandom);
        tick;
        chk("gap_we", bus.mem_we, 0);
      end
      chk("ready", bus.in_ready, 1);
      bus.in_valid = 1;
      bus.in_data = w[i];
      bus.in_last = last && i == n - 1;
      tick;
    end
    bus.in_valid = 0;
    bus.in_last = 0;
  endtask
  task automatic finish(input string nm, input prog_t w, input int n, input logic [AW:0] len,
                        input logic [IW-1:0] sum, input bit err);
    chk({nm, "_lastwe"}, bus.mem_we, 1);
    chk({nm, "_lastaddr"}, bus.mem_addr, n - 1);
    chk({nm, "_hold_run"}, cpu_run, 0);
    chk({nm, "_hold_ready"}, bus.in_ready, 0);
    chk({nm, "_err"}, err_overflow, err);
    if (err) begin
      halt = 1;
      tick;
      halt = 0;
      tick;
      chk({nm, "_err_stays"}, err_overflow, 1);
      chk({nm, "_err_run"}, cpu_run, 0);
    end else begin
      tick;
      chk({nm, "_run"}, cpu_run, 1);
      chk({nm, "_done"}, done, 1);
      tick;
      chk({nm, "_done_pulse"}, done, 0);
    end
    chk({nm, "_done_cnt"}, done_cnt, err ? 0 : 1);
    chk({nm, "_nwrites"}, wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      chk({nm, "_write"}, wq[i], {i[AW-1:0], w[i]});
    chk({nm, "_len"}, prog_len, len);
    chk({nm, "_csum"}, csum, sum);
  endtask
  function automatic logic [IW-1:0] model_sum(input prog_t w, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s = (s + int'(w[i])) % (1 << IW);
    return IW'(s);
  endfunction
  initial begin
    prog_t rw;
    tab[0] = '{"tp6", '{16'h4810, 16'h4A12, 16'h4C14, 16'h4E16, 16'h0880, 16'h500A, 16'h0, 16'h0},
               6, 8'h00, 1'b1, 4'd6, 16'h84D6, 1'b0};
    tab[1] = '{"gap6", '{16'h4810, 16'h4A12, 16'h4C14, 16'h4E16, 16'h0880, 16'h500A, 16'h0, 16'h0},
               6, 8'hFE, 1'b1, 4'd6, 16'h84D6, 1'b0};
    tab[2] = '{"ovf8", '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8},
               8, 8'h00, 1'b0, 4'd8, 16'h0024, 1'b1};
    tab[3] = '{"two", '{16'h1234, 16'h0101, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
               2, 8'h00, 1'b1, 4'd2, 16'h1335, 1'b0};
    tab[4] = '{"ffff", '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
               1, 8'h00, 1'b1, 4'd1, 16'hFFFF, 1'b0};
    tab[5] = '{"wrap", '{16'hFFFF, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
               2, 8'h00, 1'b1, 4'd2, 16'h0001, 1'b0};
    tab[6] = '{"full8", '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h8000},
               8, 8'h55, 1'b1, 4'd8, 16'h4000, 1'b0};
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_last = 0;
    repeat (2) tick;
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_csum", csum, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_overflow, 0);
    rst_n = 1;
    tick;
    chk("idle_ready", bus.in_ready, 0);
    foreach (tab[k]) begin
      start_load;
      feed(tab[k].w, tab[k].n, tab[k].gaps, tab[k].last);
      finish(tab[k].name, tab[k].w, tab[k].n, tab[k].len, tab[k].sum, tab[k].err);
    end
    // halt and load_start together in RUN: load wins
    halt = 1;
    load_start = 1;
    tick;
    halt = 0;
    load_start = 0;
    chk("prio_ready", bus.in_ready, 1);
    chk("prio_run", cpu_run, 0);
    chk("prio_csum", csum, 0);
    chk("prio_len", prog_len, 0);
    wq.delete();
    done_cnt = 0;
    halt = 1;
    load_start = 1;
    tick;
    halt = 0;
    load_start = 0;
    chk("load_ignores_halt", bus.in_ready, 1);
    rw = '{16'h0042, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    feed(rw, 1, 8'h00, 1'b1);
    finish("prio", rw, 1, 4'd1, 16'h0042, 1'b0);
    halt = 1;
    tick;
    halt = 0;
    chk("halt_run", cpu_run, 0);
    chk("halt_ready", bus.in_ready, 0);
    chk("halt_len_hold", prog_len, 1);
    chk("halt_csum_hold", csum, 16'h0042);
    bus.in_valid = 1;
    tick;
    bus.in_valid = 0;
    tick;
    chk("idle_no_we", bus.mem_we, 0);
    chk("idle_stays", cpu_run, 0);
    // asynchronous reset in the middle of a load
    start_load;
    rw = '{16'hA001, 16'hA002, 16'hA003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    feed(rw, 3, 8'h00, 1'b0);
    chk("mid_len", prog_len, 3);
    #2 rst_n = 0;
    #1;
    chk("arst_ready", bus.in_ready, 0);
    chk("arst_we", bus.mem_we, 0);
    chk("arst_addr", bus.mem_addr, 0);
    chk("arst_wdata", bus.mem_wdata, 0);
    chk("arst_len", prog_len, 0);
    chk("arst_csum", csum, 0);
    chk("arst_run", cpu_run, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err_overflow, 0);
    tick;
    rst_n = 1;
    tick;
    chk("post_rst_ready", bus.in_ready, 0);
    chk("post_rst_run", cpu_run, 0);
    for (int r = 0; r < 25; r++) begin
      bit ovf;
      int n;
      logic [7:0] gaps;
      ovf = ($urandom % 4) == 0;
      n = ovf ? DEPTH : int'($urandom_range(1, DEPTH));
      gaps = 8'($urandom);
      foreach (rw[i]) rw[i] = IW'($urandom);
      start_load;
      feed(rw, n, gaps, !ovf);
      finish("rnd", rw, n, (AW + 1)'(n), model_sum(rw, n), ovf);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
